// File: rtl/fifo_66_pkg.sv
// Shared definitions for the 66-bit compressor FIFO drain.
package fifo_66_pkg;
    localparam int TYPE_MSB  = 65;
    localparam int TYPE_LSB  = 64;
    localparam int PAYLOAD_W = 64;
    localparam int ENTRY_W   = 66;
    localparam int BEAT_W    = 32;

    typedef enum logic [1:0] {
        TYPE_PAD  = 2'b00,
        TYPE_FULL = 2'b01,
        TYPE_HALF = 2'b10,
        TYPE_LAST = 2'b11
    } entry_type_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_66_drain_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + W'(1);
    end
endmodule

// File: rtl/fifo_66_drain.sv
// Pops 66-bit FIFO entries and re-emits them as 32-bit valid/ready beats,
// dropping pad entries and flagging block ends.
module fifo_66_drain
    import fifo_66_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int DROP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [65:0]        fifo_data_i,
    input  logic               fifo_empty_i,
    output logic               fifo_rd_o,
    output logic [31:0]        dout_o,
    output logic               valid_o,
    output logic               last_o,
    input  logic               ready_i,
    output logic [CNT_W-1:0]   beat_cnt_o,
    output logic [CNT_W-1:0]   blk_cnt_o,
    output logic [DROP_W-1:0]  drop_cnt_o,
    output logic               busy_o
);
    state_t               state, state_next;
    logic [ENTRY_W-1:0]   held;
    entry_type_t          held_type, head_type;
    logic                 hs, entry_done, load_ok;

    assign held_type = entry_type_t'(held[TYPE_MSB:TYPE_LSB]);
    assign head_type = entry_type_t'(fifo_data_i[TYPE_MSB:TYPE_LSB]);

    assign hs         = valid_o & ready_i;
    assign entry_done = hs & ((state == S_HI) | ((state == S_LO) & (held_type == TYPE_HALF)));
    assign load_ok    = (state == S_IDLE) | entry_done;
    assign fifo_rd_o  = load_ok & ~fifo_empty_i;

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // A pop at the end of an entry chains straight into the next one, so no bubble.
    always_comb begin
        state_next = state;
        if (fifo_rd_o)
            state_next = (head_type == TYPE_PAD) ? S_IDLE : S_LO;
        else if (entry_done)
            state_next = S_IDLE;
        else if (hs && (state == S_LO))
            state_next = S_HI;
    end

    always_comb begin
        valid_o = 1'b0;
        last_o  = 1'b0;
        dout_o  = '0;
        case (state)
            S_LO: begin
                valid_o = 1'b1;
                dout_o  = held[BEAT_W-1:0];
            end
            S_HI: begin
                valid_o = 1'b1;
                last_o  = (held_type == TYPE_LAST);
                dout_o  = held[PAYLOAD_W-1:BEAT_W];
            end
            default: ;
        endcase
    end

    assign busy_o = (state != S_IDLE);

    // Entry payload needs no reset: it is only presented once state leaves S_IDLE.
    always_ff @(posedge clk) begin
        if (fifo_rd_o)
            held <= fifo_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_o <= '0;
            blk_cnt_o  <= '0;
        end else if (hs) begin
            beat_cnt_o <= beat_cnt_o + CNT_W'(1);
            if (last_o)
                blk_cnt_o <= blk_cnt_o + CNT_W'(1);
        end
    end

    sat_counter #(.W(DROP_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (fifo_rd_o && (head_type == TYPE_PAD)),
        .count (drop_cnt_o)
    );
endmodule

// File: tb/tb_fifo_66_drain.sv
// Scoreboard bench: a queue-based FIFO feeds the drain, expected beats are derived per entry.
module tb_fifo_66_drain;
    localparam int CNT_W  = 16;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [65:0]       fifo_data_i;
    logic              fifo_empty_i;
    logic              fifo_rd_o;
    logic [31:0]       dout_o;
    logic              valid_o;
    logic              last_o;
    logic              ready_i;
    logic [CNT_W-1:0]  beat_cnt_o;
    logic [CNT_W-1:0]  blk_cnt_o;
    logic [DROP_W-1:0] drop_cnt_o;
    logic              busy_o;

    fifo_66_drain #(.CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_data_i  (fifo_data_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_o    (fifo_rd_o),
        .dout_o       (dout_o),
        .valid_o      (valid_o),
        .last_o       (last_o),
        .ready_i      (ready_i),
        .beat_cnt_o   (beat_cnt_o),
        .blk_cnt_o    (blk_cnt_o),
        .drop_cnt_o   (drop_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    logic [65:0]      fq[$];
    logic [32:0]      exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               pad_cnt = 0;
    int               pop_cnt = 0;
    logic [15:0]      mb = '0, mk = '0;
    logic             fp, fe, fr;
    logic             stall_prev = 1'b0;
    logic [32:0]      prev_beat = '0;
    logic [32:0]      want;

    function automatic void refresh();
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() == 0) ? 66'd0 : fq[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, req);
        end
    endtask

    // Reference: each entry type maps to a fixed list of {last, data} beats.
    task automatic push_entry(input logic [1:0] t, input logic [63:0] p);
        fq.push_back({t, p});
        case (t)
            2'b00: pad_cnt++;
            2'b01: begin exp_q.push_back({1'b0, p[31:0]}); exp_q.push_back({1'b0, p[63:32]}); end
            2'b10: exp_q.push_back({1'b0, p[31:0]});
            default: begin exp_q.push_back({1'b0, p[31:0]}); exp_q.push_back({1'b1, p[63:32]}); end
        endcase
        refresh();
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while ((fq.size() != 0 || exp_q.size() != 0 || busy_o !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout got %0d cycles want < %0d", name, n, budget);
        end
    endtask

    // FIFO model: pops on the edge where the drain requested a read; reset empties it.
    always @(posedge clk) begin
        fp = fifo_rd_o;
        fe = fifo_empty_i;
        fr = rst;
        #1;
        checks++;
        if (fp === 1'b1 && fe === 1'b1) begin
            errors++;
            $display("FAIL rd_while_empty got 1 want 0");
        end
        if (fr === 1'b1)
            fq.delete();
        else if (fp === 1'b1 && fe === 1'b0) begin
            void'(fq.pop_front());
            pop_cnt++;
        end
        refresh();
    end

    // Monitor: compares accepted beats, stall stability and counters.
    always @(negedge clk) begin
        if (rst !== 1'b0) begin
            exp_q.delete();
            mb = '0;
            mk = '0;
            pad_cnt = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (valid_o !== 1'b1 || {last_o, dout_o} !== prev_beat) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b %h want v=1 %h", valid_o, {last_o, dout_o}, prev_beat);
                end
            end
            checks++;
            if (beat_cnt_o !== mb || blk_cnt_o !== mk) begin
                errors++;
                $display("FAIL counters got %0d/%0d want %0d/%0d", beat_cnt_o, blk_cnt_o, mb, mk);
            end
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got %h want none", {last_o, dout_o});
                end else begin
                    want = exp_q.pop_front();
                    if ({last_o, dout_o} !== want) begin
                        errors++;
                        $display("FAIL beat got %h want %h", {last_o, dout_o}, want);
                    end
                    mb = mb + 16'd1;
                    if (want[32]) mk = mk + 16'd1;
                end
            end
            stall_prev = (valid_o === 1'b1) && (ready_i !== 1'b1);
            prev_beat  = {last_o, dout_o};
        end
    end

    initial begin
        int p0;
        logic [15:0] b0;
        rst = 1'b1;
        ready_i = 1'b0;
        refresh();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_valid", valid_o, 0);
        chk("rst_dout", dout_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_beat_cnt", beat_cnt_o, 0);
        chk("rst_drop_cnt", drop_cnt_o, 0);

        // Single FULL entry: one-cycle pop, then two beats
        ready_i = 1'b1;
        push_entry(2'b01, 64'h1111_2222_3333_4444);
        #1;
        chk("lat_rd", fifo_rd_o, 1);
        tick();
        chk("lat_valid", valid_o, 1);
        chk("rd_pulse", fifo_rd_o, 0);
        wait_idle(20, "full");
        chk("full_beat_cnt", beat_cnt_o, 2);

        // LAST, HALF, LAST back-to-back must stream without gaps
        push_entry(2'b11, {$urandom, $urandom});
        push_entry(2'b10, {$urandom, $urandom});
        push_entry(2'b11, {$urandom, $urandom});
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("no_gap", valid_o, 1);
            tick();
        end
        chk("after_burst_valid", valid_o, 0);
        chk("blk_cnt", blk_cnt_o, 2);

        // Pads only: no beats, drop counter saturates
        for (int i = 0; i < 300; i++) push_entry(2'b00, {$urandom, $urandom});
        wait_idle(400, "pads");
        chk("drop_sat", drop_cnt_o, 8'hFF);

        // FULL entry under random back-pressure
        ready_i = 1'b0;
        p0 = pop_cnt;
        b0 = mb;
        push_entry(2'b01, {$urandom, $urandom});
        for (int i = 0; i < 30; i++) begin
            ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        ready_i = 1'b1;
        wait_idle(20, "stall");
        chk("stall_pops", pop_cnt - p0, 1);
        chk("stall_beats", mb - b0, 2);

        // Random mix of entries and back-pressure
        for (int i = 0; i < 150; i++) push_entry(2'($urandom_range(0, 3)), {$urandom, $urandom});
        for (int i = 0; i < 600 && (fq.size() != 0 || exp_q.size() != 0); i++) begin
            ready_i = ($urandom_range(0, 9) < 7);
            tick();
        end
        ready_i = 1'b1;
        wait_idle(400, "random");
        chk("drop_after_mix", drop_cnt_o, 8'hFF);

        // Reset while the high half of a LAST entry is on the bus
        ready_i = 1'b0;
        push_entry(2'b11, {$urandom, $urandom});
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        chk("pre_rst_last", last_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", valid_o, 0);
        chk("midrst_beat_cnt", beat_cnt_o, 0);
        chk("midrst_blk_cnt", blk_cnt_o, 0);
        chk("midrst_drop_cnt", drop_cnt_o, 0);
        chk("midrst_busy", busy_o, 0);
        ready_i = 1'b1;
        push_entry(2'b01, {$urandom, $urandom});
        wait_idle(20, "post_rst");
        chk("post_rst_beats", beat_cnt_o, 2);

        // Beat counter wrap
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 65539; i++) push_entry(2'b10, {$urandom, $urandom});
        wait_idle(70000, "wrap");
        chk("wrap_beat_cnt", beat_cnt_o, 3);
        chk("wrap_blk_cnt", blk_cnt_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
